// File: rtl/memory_responder.sv
// Request-driven responder around a single-port synchronous RAM: one-word read, two-word
// read or write per accepted request, with registered status and data outputs.
module memory_responder #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 66
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        mem_func,
   input  logic              execute,
   input  logic [ADDR_W-1:0] address1,
   input  logic [ADDR_W-1:0] address2,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              busy,
   output logic              finished,
   output logic              error
);

   localparam logic [1:0] FuncRead1 = 2'b00;
   localparam logic [1:0] FuncRead2 = 2'b01;
   localparam logic [1:0] FuncWrite = 2'b10;

   typedef enum logic [2:0] {StIdle, StRa, StCa, StRb, StCb, StWr} state_e;

   state_e state_q, state_d;

   logic [1:0]        func_q;
   logic [ADDR_W-1:0] addr1_q, addr2_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept;
   logic              rd1_en, rd2_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_q;
   logic              busy_d, finished_d, error_d;

   logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      rd1_en     = 1'b0;
      rd2_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr1_q;
      finished_d = 1'b0;
      error_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (execute) begin
               accept = 1'b1;
               case (mem_func)
                  FuncRead1, FuncRead2: state_d = StRa;
                  FuncWrite:            state_d = StWr;
                  default: begin
                     finished_d = 1'b1;
                     error_d    = 1'b1;
                  end
               endcase
            end
         end
         StRa: state_d = StCa;
         StCa: begin
            rd1_en = 1'b1;
            if (func_q == FuncRead2) begin
               state_d = StRb;
            end else begin
               state_d    = StIdle;
               finished_d = 1'b1;
            end
         end
         StRb: begin
            ram_addr = addr2_q;
            state_d  = StCb;
         end
         StCb: begin
            rd2_en     = 1'b1;
            finished_d = 1'b1;
            state_d    = StIdle;
         end
         StWr: begin
            ram_we     = 1'b1;
            finished_d = 1'b1;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         func_q     <= '0;
         addr1_q    <= '0;
         addr2_q    <= '0;
         wdata_q    <= '0;
         read_data1 <= '0;
         read_data2 <= '0;
         busy       <= 1'b0;
         finished   <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy     <= busy_d;
         finished <= finished_d;
         error    <= error_d;
         if (accept) begin
            func_q  <= mem_func;
            addr1_q <= address1;
            addr2_q <= address2;
            wdata_q <= write_data;
         end
         if (rd1_en) read_data1 <= ram_q;
         if (rd2_en) read_data2 <= ram_q;
      end
   end

   // RAM contents are deliberately outside the reset domain; a write is gated by state, so a
   // reset that lands in WR suppresses it.
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= wdata_q;
      ram_q <= mem[ram_addr];
   end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a model RAM predicts each request's outputs into a
// scoreboard queue that is drained and compared when finished pulses.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  mem_func = '0;
   logic        execute = 1'b0;
   logic [9:0]  address1 = '0;
   logic [9:0]  address2 = '0;
   logic [65:0] write_data = '0;
   logic [65:0] read_data1, read_data2;
   logic        busy, finished, error;

   memory_responder #(.ADDR_W(10), .DATA_W(66)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_func   (mem_func),
      .execute    (execute),
      .address1   (address1),
      .address2   (address2),
      .write_data (write_data),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .busy       (busy),
      .finished   (finished),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [65:0] d1;
      logic [65:0] d2;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [65:0] mem_m [logic [9:0]];
   logic [65:0] rd1_m = '0;
   logic [65:0] rd2_m = '0;
   int          n_assert = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a request's inputs and push the model's prediction of the outputs at completion.
   task automatic issue(input logic [1:0] f, input logic [9:0] x1, input logic [9:0] x2,
                        input logic [65:0] d);
      exp_t e;
      mem_func   = f;
      address1   = x1;
      address2   = x2;
      write_data = d;
      e.err      = 1'b0;
      case (f)
         2'b00: rd1_m = mem_m[x1];
         2'b01: begin
            rd1_m = mem_m[x1];
            rd2_m = mem_m[x2];
         end
         2'b10: mem_m[x1] = d;
         default: e.err = 1'b1;
      endcase
      e.d1 = rd1_m;
      e.d2 = rd2_m;
      sb.push_back(e);
   endtask

   // Called just after the accept edge; lat counts edges from accept to the finished edge.
   task automatic wait_finish(input string tag, input int exp_lat);
      int   lat = 0;
      exp_t e;
      while (!finished && lat < 16) begin
         check({tag, " busy"}, busy, 1);
         tick();
         lat++;
      end
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " busy at finish"}, busy, 0);
      check({tag, " sb nonempty"}, sb.size() != 0, 1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, " read_data1"}, read_data1, e.d1);
         check({tag, " read_data2"}, read_data2, e.d2);
         check({tag, " error"}, error, e.err);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] f, input logic [9:0] x1,
                         input logic [9:0] x2, input logic [65:0] d, input int exp_lat);
      issue(f, x1, x2, d);
      execute = 1'b1;
      tick();
      execute = 1'b0;
      wait_finish(tag, exp_lat);
      tick();
      check({tag, " finished pulse"}, finished, 0);
      check({tag, " error pulse"}, error, 0);
   endtask

   initial begin
      // Asynchronous reset, observed before any clock edge.
      #1 rst = 1'b1;
      #1;
      check("rst read_data1", read_data1, 0);
      check("rst read_data2", read_data2, 0);
      check("rst busy", busy, 0);
      check("rst finished", finished, 0);
      check("rst error", error, 0);
      tick();
      rst = 1'b0;

      run_op("wr 005", 2'b10, 10'h005, 10'h000, 66'h1234, 1);
      run_op("rd1 005", 2'b00, 10'h005, 10'h000, 66'h0, 2);

      run_op("wr 010", 2'b10, 10'h010, 10'h000, 66'hAA, 1);
      run_op("wr 011", 2'b10, 10'h011, 10'h000, 66'hBB, 1);
      run_op("rd2 010/011", 2'b01, 10'h010, 10'h011, 66'h0, 4);
      run_op("rd1 010", 2'b00, 10'h010, 10'h000, 66'h0, 2);

      run_op("wr 020", 2'b10, 10'h020, 10'h000, 66'h77, 1);
      run_op("wr 3a5", 2'b10, 10'h3A5, 10'h000, {2'b10, 64'hDEAD_BEEF_0123_4567}, 1);
      run_op("rd1 3a5", 2'b00, 10'h3A5, 10'h000, 66'h0, 2);
      run_op("reserved", 2'b11, 10'h005, 10'h010, 66'h55, 0);

      // execute held high with the inputs changed mid-flight: one READ2 with captured
      // addresses, then the next request taken on the edge right after finished.
      issue(2'b01, 10'h010, 10'h011, 66'h0);
      execute = 1'b1;
      tick();
      mem_func   = 2'b10;
      address1   = 10'h020;
      address2   = 10'h005;
      write_data = '1;
      wait_finish("hold rd2", 4);
      issue(2'b00, 10'h005, 10'h000, 66'h0);
      tick();
      check("b2b accepted", busy, 1);
      execute = 1'b0;
      wait_finish("b2b rd1", 2);
      tick();
      check("b2b finished pulse", finished, 0);

      run_op("rd2 020/020", 2'b01, 10'h020, 10'h020, 66'h0, 4);

      // Reset while in WR, released before the next edge: write dropped, no finished.
      run_op("wr 3ff", 2'b10, 10'h3FF, 10'h000, 66'h0, 1);
      mem_func   = 2'b10;
      address1   = 10'h3FF;
      write_data = 66'hFF;
      execute    = 1'b1;
      tick();
      execute = 1'b0;
      check("abort busy", busy, 1);
      rst = 1'b1;
      #1;
      check("abort read_data1", read_data1, 0);
      check("abort read_data2", read_data2, 0);
      check("abort busy after rst", busy, 0);
      check("abort finished", finished, 0);
      rst   = 1'b0;
      rd1_m = '0;
      rd2_m = '0;
      issue(2'b00, 10'h3FF, 10'h000, 66'h0);
      execute = 1'b1;
      tick();
      execute = 1'b0;
      wait_finish("rd1 3ff after rst", 2);

      check("sb drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width; RAM depth 2^ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 66: word width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port mem_func, input, 2 bits: opcode; 00 READ1, 01 READ2, 10 WRITE, 11 reserved.
REQ-006 SHALL have port execute, input, 1 bit: request strobe.
REQ-007 SHALL have port address1, input, ADDR_W bits: first or write address.
REQ-008 SHALL have port address2, input, ADDR_W bits: second read address.
REQ-009 SHALL have port write_data, input, DATA_W bits: WRITE payload.
REQ-010 SHALL have port read_data1, output, DATA_W bits: word read at address1.
REQ-011 SHALL have port read_data2, output, DATA_W bits: word read at address2.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port finished, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port error, output, 1 bit: one-cycle pulse, reserved opcode.

Function
REQ-015 SHALL contain a single-port synchronous RAM, 2^ADDR_W x DATA_W; address sampled at the edge, data available after that edge (read latency 1).
REQ-016 SHALL implement states IDLE, RA, CA, RB, CB, WR; all outputs registered.
REQ-017 SHALL accept a request only when execute=1 at an edge while in IDLE; mem_func, address1, address2, write_data captured into internal registers at that edge.
REQ-018 SHALL ignore execute while busy=1; captured request unaffected by later input changes.
REQ-019 READ1 (accept edge N): IDLE->RA at N; RAM samples address1 at N+1 (->CA); at N+2 read_data1<=RAM output, finished<=1, ->IDLE.
REQ-020 READ2: as READ1, but at N+2 read_data1 captured and ->RB; RAM samples address2 at N+3 (->CB); at N+4 read_data2 captured, finished<=1, ->IDLE.
REQ-021 WRITE: IDLE->WR at N; RAM writes write_data to address1 at N+1; finished<=1, ->IDLE at N+1.
REQ-022 Reserved 11: stays IDLE; finished<=1 and error<=1 at N; RAM and read_data untouched.
REQ-023 finished and error SHALL be high exactly one cycle per completion; busy SHALL be low in that cycle.
REQ-024 A new request SHALL be acceptable at the edge immediately after the one that raised finished (back-to-back operation).
REQ-025 read_data1/read_data2 SHALL hold their values until overwritten by a later read; READ1 SHALL not modify read_data2; WRITE SHALL modify neither.
REQ-026 READ2 with address1==address2 SHALL return the same word on both outputs.
REQ-027 A READ of an address written by the immediately preceding WRITE SHALL return the new data.

Reset
REQ-028 On rst=1, asynchronously: state IDLE; read_data1, read_data2, busy, finished, error all 0; captured request registers 0.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 rst asserted mid-operation SHALL abort it with no finished pulse; rst asserted before the WR write edge SHALL prevent the write.
REQ-031 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-032 WRITE addr1=0x005, data=0x1234 at edge N -> busy=1 after N, finished=1 after N+1; then READ1 addr1=0x005 -> read_data1=0x1234 two edges after its accept.
REQ-033 Preload 0x010=0xAA, 0x011=0xBB; READ2 addr1=0x010, addr2=0x011 -> finished after N+4; read_data1=0xAA, read_data2=0xBB.
REQ-034 execute held high with changing addresses through a READ2 -> exactly one transaction, original addresses used; next accepted at the edge after finished.
REQ-035 mem_func=11 -> finished=1 and error=1 one cycle after accept, busy stays 0, read_data unchanged.
REQ-036 rst pulsed while in WR (before the write edge) for WRITE 0x3FF=0xFF over prior 0x00 -> no finished pulse, outputs 0; READ1 0x3FF returns 0x00.
REQ-037 READ2 addr1=addr2=0x020 (holding 0x77) -> read_data1=read_data2=0x77.
